// File: rtl/tamagotchi_pkg.sv
// Shared display constants: active-low glyphs, digit indices, anode helpers.
// Pure declarations, no timing and no handshakes.
package tamagotchi_pkg;

  typedef logic [1:0] nivel_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ALL   = 7'b0000000;

  localparam logic [1:0] DIG_ANIMO    = 2'd0;
  localparam logic [1:0] DIG_ENERGIA  = 2'd1;
  localparam logic [1:0] DIG_DESCANSO = 2'd2;
  localparam logic [1:0] DIG_MEDICINA = 2'd3;

  localparam logic [3:0] ANODO_OFF = 4'b1111;

  // One anode low for the given digit index.
  function automatic logic [3:0] anodo_de(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Level 0-3 to active-low gfedcba glyph; purely combinational, zero latency,
// no flow control.
module decodificador_7seg
  import tamagotchi_pkg::*;
(
  input  logic [1:0] nivel,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nivel)
      2'd0: seg = SEG_0;
      2'd1: seg = SEG_1;
      2'd2: seg = SEG_2;
      2'd3: seg = SEG_3;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/visor_niveles_7seg.sv
// Multiplexed 4-digit level display with blinking critical levels and lamp test.
// Outputs registered (1 clk after scan state); free-running, no backpressure.
module visor_niveles_7seg
  import tamagotchi_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 4_000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       B_Reset,
  input  logic       B_Test,
  input  logic [1:0] LED_Animo,
  input  logic [1:0] LED_Energia,
  input  logic [1:0] LED_Descanso,
  input  logic [1:0] LED_Medicina,
  output logic [3:0] anodo,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(HALF - 1);

  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic [3:0][1:0] sombra;
  logic [BW-1:0]   bcnt;
  logic            oculto;
  logic            test_m;
  logic            test_s;

  logic [1:0] nivel_sel;
  logic [6:0] glifo;
  logic [3:0] anodo_nx;
  logic [6:0] seg_nx;
  logic       dp_nx;

  always_ff @(posedge clk or negedge B_Reset) begin
    if (!B_Reset) begin
      cnt    <= '0;
      idx    <= DIG_ANIMO;
      sombra <= '0;
      bcnt   <= '0;
      oculto <= 1'b0;
      test_m <= 1'b0;
      test_s <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
        // Latch all levels together at frame end so a frame never mixes old and new.
        if (idx == DIG_MEDICINA) begin
          sombra <= {LED_Medicina, LED_Descanso, LED_Energia, LED_Animo};
        end
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (bcnt == BLK_LAST) begin
        bcnt   <= '0;
        oculto <= ~oculto;
      end else begin
        bcnt <= bcnt + 1'b1;
      end

      test_m <= B_Test;
      test_s <= test_m;
    end
  end

  assign nivel_sel = sombra[idx];

  decodificador_7seg u_deco (
    .nivel (nivel_sel),
    .seg   (glifo)
  );

  // Slot cycle 0 is always dark to avoid ghosting between digits.
  always_comb begin
    anodo_nx = ANODO_OFF;
    seg_nx   = SEG_BLANK;
    dp_nx    = 1'b1;
    if (cnt != '0) begin
      if (test_s) begin
        anodo_nx = anodo_de(idx);
        seg_nx   = SEG_ALL;
        dp_nx    = 1'b0;
      end else if (!(oculto && (nivel_sel == 2'd0))) begin
        anodo_nx = anodo_de(idx);
        seg_nx   = glifo;
        dp_nx    = (nivel_sel != 2'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge B_Reset) begin
    if (!B_Reset) begin
      anodo <= ANODO_OFF;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      anodo <= anodo_nx;
      seg   <= seg_nx;
      dp    <= dp_nx;
    end
  end

endmodule

// File: tb/tb_visor_niveles_7seg.sv
// Directed bench for visor_niveles_7seg at DIV=4, HALF=8 (16-cycle frame and blink period).
module tb_visor_niveles_7seg;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] GB = 7'b1111111;
  localparam logic [6:0] GA = 7'b0000000;

  logic       clk = 1'b0;
  logic       B_Reset = 1'b0;
  logic       B_Test = 1'b0;
  logic [1:0] LED_Animo = 2'd3;
  logic [1:0] LED_Energia = 2'd3;
  logic [1:0] LED_Descanso = 2'd3;
  logic [1:0] LED_Medicina = 2'd3;
  logic [3:0] anodo;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  visor_niveles_7seg #(
    .CLK_HZ   (16),
    .SCAN_HZ  (4),
    .BLINK_HZ (1)
  ) dut (
    .clk          (clk),
    .B_Reset      (B_Reset),
    .B_Test       (B_Test),
    .LED_Animo    (LED_Animo),
    .LED_Energia  (LED_Energia),
    .LED_Descanso (LED_Descanso),
    .LED_Medicina (LED_Medicina),
    .anodo        (anodo),
    .seg          (seg),
    .dp           (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a, e, d, m;
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(input logic [1:0] a, e, d, m,
                              input logic [3:0] an, input logic [6:0] sg, input logic p);
    vec_t v;
    v.a = a; v.e = e; v.d = d; v.m = m;
    v.an = an; v.sg = sg; v.dp = p;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] an, input logic [6:0] sg, input logic p);
    checks++;
    if (anodo !== an || seg !== sg || dp !== p) begin
      errors++;
      $display("FAIL %s: got anodo=%b seg=%b dp=%b, expected anodo=%b seg=%b dp=%b",
               tag, anodo, seg, dp, an, sg, p);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    // Inputs in a frame's last slot become that frame's successor shadows.
    // Slots at idx 2/3 always fall in the hidden blink phase with these parameters.
    // Frame 0: shadows still zero.
    tbl[0]  = mk(1, 2, 3, 1, 4'b1110, G0, 1'b0);
    tbl[1]  = mk(1, 2, 3, 1, 4'b1101, G0, 1'b0);
    tbl[2]  = mk(1, 2, 3, 1, 4'b1111, GB, 1'b1);
    tbl[3]  = mk(1, 2, 3, 1, 4'b1111, GB, 1'b1);
    // Frame 1: 1,2,3,1.
    tbl[4]  = mk(1, 2, 3, 1, 4'b1110, G1, 1'b1);
    tbl[5]  = mk(1, 2, 3, 1, 4'b1101, G2, 1'b1);
    tbl[6]  = mk(1, 2, 3, 1, 4'b1011, G3, 1'b1);
    tbl[7]  = mk(1, 2, 3, 1, 4'b0111, G1, 1'b1);
    // Frame 2: energia changes 2->3 while idx==2, not visible yet.
    tbl[8]  = mk(1, 2, 3, 1, 4'b1110, G1, 1'b1);
    tbl[9]  = mk(1, 2, 3, 1, 4'b1101, G2, 1'b1);
    tbl[10] = mk(1, 3, 3, 1, 4'b1011, G3, 1'b1);
    tbl[11] = mk(1, 3, 3, 1, 4'b0111, G1, 1'b1);
    // Frame 3: energia now 3.
    tbl[12] = mk(3, 3, 0, 3, 4'b1110, G1, 1'b1);
    tbl[13] = mk(3, 3, 0, 3, 4'b1101, G3, 1'b1);
    tbl[14] = mk(3, 3, 0, 3, 4'b1011, G3, 1'b1);
    tbl[15] = mk(3, 3, 0, 3, 4'b0111, G1, 1'b1);
    // Frame 4: descanso critical, hidden.
    tbl[16] = mk(3, 3, 0, 3, 4'b1110, G3, 1'b1);
    tbl[17] = mk(3, 3, 0, 3, 4'b1101, G3, 1'b1);
    tbl[18] = mk(3, 3, 0, 3, 4'b1111, GB, 1'b1);
    tbl[19] = mk(3, 0, 3, 3, 4'b0111, G3, 1'b1);
    // Frame 5: energia critical in visible phase.
    tbl[20] = mk(3, 0, 3, 3, 4'b1110, G3, 1'b1);
    tbl[21] = mk(3, 0, 3, 3, 4'b1101, G0, 1'b0);
    tbl[22] = mk(3, 0, 3, 3, 4'b1011, G3, 1'b1);
    tbl[23] = mk(0, 3, 3, 0, 4'b0111, G3, 1'b1);
    // Frame 6: animo critical visible, medicina critical hidden.
    tbl[24] = mk(3, 3, 0, 3, 4'b1110, G0, 1'b0);
    tbl[25] = mk(3, 3, 0, 3, 4'b1101, G3, 1'b1);
    tbl[26] = mk(3, 3, 0, 3, 4'b1011, G3, 1'b1);
    tbl[27] = mk(3, 3, 0, 3, 4'b1111, GB, 1'b1);

    repeat (5) begin
      tick();
      chk("reset_hold", 4'b1111, GB, 1'b1);
    end

    B_Reset = 1'b1;
    for (int i = 0; i < 28; i++) begin
      LED_Animo    = tbl[i].a;
      LED_Energia  = tbl[i].e;
      LED_Descanso = tbl[i].d;
      LED_Medicina = tbl[i].m;
      tick();
      chk($sformatf("vec%0d_blank", i), 4'b1111, GB, 1'b1);
      for (int c = 0; c < 3; c++) begin
        tick();
        chk($sformatf("vec%0d_lit%0d", i, c), tbl[i].an, tbl[i].sg, tbl[i].dp);
      end
    end

    // Frame 7 (shadows 3,3,0,3): lamp test; descanso 2 loads for frame 8.
    B_Test = 1'b1;
    LED_Descanso = 2'd2;
    tick(); chk("lamp_blank0", 4'b1111, GB, 1'b1);
    tick(); chk("lamp_sync", 4'b1110, G3, 1'b1);
    tick(); chk("lamp_on_a0", 4'b1110, GA, 1'b0);
    tick(); chk("lamp_on_a1", 4'b1110, GA, 1'b0);
    tick(); chk("lamp_blank1", 4'b1111, GB, 1'b1);
    repeat (3) begin tick(); chk("lamp_e", 4'b1101, GA, 1'b0); end
    tick(); chk("lamp_blank2", 4'b1111, GB, 1'b1);
    repeat (3) begin tick(); chk("lamp_d_hidden", 4'b1011, GA, 1'b0); end
    tick(); chk("lamp_blank3", 4'b1111, GB, 1'b1);
    repeat (3) begin tick(); chk("lamp_m", 4'b0111, GA, 1'b0); end

    B_Test = 1'b0;
    tick(); chk("unlamp_blank", 4'b1111, GB, 1'b1);
    tick(); chk("unlamp_lag", 4'b1110, GA, 1'b0);
    tick(); chk("unlamp_a0", 4'b1110, G3, 1'b1);
    tick(); chk("unlamp_a1", 4'b1110, G3, 1'b1);
    tick(); chk("f8_blank1", 4'b1111, GB, 1'b1);
    repeat (3) begin tick(); chk("f8_e", 4'b1101, G3, 1'b1); end
    tick(); chk("f8_blank2", 4'b1111, GB, 1'b1);
    tick(); chk("f8_d", 4'b1011, G2, 1'b1);

    // Asynchronous reset in the middle of the descanso slot.
    B_Reset = 1'b0;
    #1;
    chk("rst_async", 4'b1111, GB, 1'b1);
    repeat (2) begin tick(); chk("rst_held", 4'b1111, GB, 1'b1); end
    B_Reset = 1'b1;
    tick(); chk("rst_rel_blank", 4'b1111, GB, 1'b1);
    tick(); chk("rst_rel_a0", 4'b1110, G0, 1'b0);
    tick(); chk("rst_rel_a1", 4'b1110, G0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
